// File: rtl/aud_dsp_v2.sv
`default_nettype none
// ============================================================================
// Module   : aud_dsp_v2
// Purpose  : Playback DSP between the SRAM controller and the audio DAC.
//            Once per DAC sample tick it fetches recorded samples and emits
//            one output sample. Modes: fast (skip N), slow sample-hold, and
//            slow linear interpolation. Also supports pause/resume, stop and
//            a bounded playback length.
// Options  : AUD_DSP_REVERSE_EN - when defined, i_reverse plays from
//            i_end_addr down to 0. When undefined, playback is forward only.
// Revision : 1.0 - initial release
// ============================================================================
module aud_dsp_v2 #(
   parameter int DATA_W    = 16,
   parameter int ADDR_W    = 20,
   parameter int SPD_W     = 4,
   parameter int MAX_SPEED = 8
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_daclrck,
   input  logic              i_start,
   input  logic              i_pause,
   input  logic              i_stop,
   input  logic [SPD_W-1:0]  i_speed,
   input  logic              i_fast,
   input  logic              i_slow_0,
   input  logic              i_slow_1,
   input  logic              i_reverse,
   input  logic [ADDR_W-1:0] i_end_addr,
   output logic              o_sram_rd,
   output logic [ADDR_W-1:0] o_sram_addr,
   input  logic [DATA_W-1:0] i_sram_data,
   output logic [DATA_W-1:0] o_dac_data,
   output logic              o_dac_valid,
   output logic              o_busy,
   output logic              o_finished
);
   localparam int PW = DATA_W + SPD_W + 2;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_WAIT  = 3'd1,
      S_FETCH = 3'd2,
      S_PAUSE = 3'd3,
      S_DONE  = 3'd4
   } state_t;

   state_t state, state_nxt;

   logic [2:0]               lr_sync;
   logic                     tick;
   logic                     mode_fast, mode_slow0, mode_slow1;
   logic [SPD_W-1:0]         speed, k;
   logic [ADDR_W-1:0]        end_addr, ptr;
   logic signed [DATA_W-1:0] samp_a, samp_b;
   logic [1:0]               step;
   logic                     b_pending, ended, pause_pend;

   logic                     mode_ok, start_ok, go_fetch, held_out, fetch_done, last_phase;
   logic [SPD_W-1:0]         speed_in;
   logic [ADDR_W-1:0]        step_amt, ptr_nxt, b_addr;
   logic [ADDR_W:0]          ptr_sum;
   logic                     past_end, b_ok;
   logic signed [DATA_W:0]   diff;
   logic signed [PW-1:0]     diff_ext, k_ext, n_ext, prod, quot;
   logic signed [DATA_W-1:0] interp;

`ifdef AUD_DSP_REVERSE_EN
   logic                     reverse;
`else
   logic                     unused_reverse;
   assign unused_reverse = i_reverse;
`endif

   assign tick   = lr_sync[1] & ~lr_sync[2];
   assign o_busy = (state != S_IDLE);

   // Synchronise the DAC LR clock; the extra stage gives rising-edge detect
   always_ff @(posedge i_clk) begin
      if (i_rst) lr_sync <= '0;
      else       lr_sync <= {lr_sync[1:0], i_daclrck};
   end

   // Next pointer, end-of-data test and neighbour address for interpolation
   always_comb begin
      step_amt = mode_fast ? ADDR_W'(speed) : ADDR_W'(1);
      ptr_sum  = {1'b0, ptr} + {1'b0, step_amt};
      ptr_nxt  = ptr_sum[ADDR_W-1:0];
      past_end = (ptr_sum > {1'b0, end_addr});
      b_ok     = (ptr < end_addr);
      b_addr   = ptr + ADDR_W'(1);
`ifdef AUD_DSP_REVERSE_EN
      if (reverse) begin
         ptr_nxt  = ptr - step_amt;
         past_end = (ptr < step_amt);
         b_ok     = (ptr != '0);
         b_addr   = ptr - ADDR_W'(1);
      end
`endif
   end

   // Interpolated sample A + trunc0((B-A)*k/N) in widened signed arithmetic
   always_comb begin
      diff     = {samp_b[DATA_W-1], samp_b} - {samp_a[DATA_W-1], samp_a};
      diff_ext = PW'(diff);
      k_ext    = PW'(k);
      n_ext    = PW'(speed);
      prod     = diff_ext * k_ext;
      quot     = prod / n_ext;
      interp   = DATA_W'(PW'(samp_a) + quot);
   end

   // State register
   always_ff @(posedge i_clk) begin
      if (i_rst) state <= S_IDLE;
      else       state <= state_nxt;
   end

   // Next-state logic and per-cycle control decisions
   always_comb begin
      state_nxt  = state;
      mode_ok    = $onehot({i_fast, i_slow_0, i_slow_1});
      speed_in   = (i_speed == '0) ? SPD_W'(1) :
                   (i_speed > SPD_W'(MAX_SPEED)) ? SPD_W'(MAX_SPEED) : i_speed;
      start_ok   = (state == S_IDLE) && i_start && !i_stop && !i_pause && mode_ok;
      last_phase = mode_fast || (k == speed - SPD_W'(1));
      go_fetch   = (state == S_WAIT) && tick && !i_stop && !i_pause && !ended &&
                   (mode_fast || (k == '0));
      held_out   = (state == S_WAIT) && tick && !i_stop && !i_pause && !ended &&
                   !(mode_fast || (k == '0));
      fetch_done = (state == S_FETCH) && !i_stop &&
                   (mode_slow1 ? (step == 2'd2) : (step == 2'd1));
      case (state)
         S_IDLE:  if (start_ok) state_nxt = S_WAIT;
         S_WAIT: begin
            if (i_stop)              state_nxt = S_IDLE;
            else if (i_pause)        state_nxt = S_PAUSE;
            else if (tick && ended)  state_nxt = S_DONE;
            else if (go_fetch)       state_nxt = S_FETCH;
         end
         S_FETCH: begin
            if (i_stop)              state_nxt = S_IDLE;
            else if (fetch_done)     state_nxt = (pause_pend || i_pause) ? S_PAUSE : S_WAIT;
         end
         S_PAUSE: begin
            if (i_stop)              state_nxt = S_IDLE;
            else if (i_pause)        state_nxt = S_WAIT;
         end
         S_DONE:                     state_nxt = S_IDLE;
         default:                    state_nxt = S_IDLE;
      endcase
   end

   // Datapath: configuration latch, SRAM reads, sample hold, phase/pointer
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         mode_fast   <= 1'b0;
         mode_slow0  <= 1'b0;
         mode_slow1  <= 1'b0;
         speed       <= SPD_W'(1);
         end_addr    <= '0;
         ptr         <= '0;
         k           <= '0;
         samp_a      <= '0;
         samp_b      <= '0;
         step        <= '0;
         b_pending   <= 1'b0;
         ended       <= 1'b0;
         pause_pend  <= 1'b0;
         o_sram_rd   <= 1'b0;
         o_sram_addr <= '0;
         o_dac_data  <= '0;
         o_dac_valid <= 1'b0;
         o_finished  <= 1'b0;
`ifdef AUD_DSP_REVERSE_EN
         reverse     <= 1'b0;
`endif
      end else begin
         o_sram_rd   <= 1'b0;
         o_dac_valid <= 1'b0;
         o_finished  <= 1'b0;
         if (i_stop && (state != S_IDLE)) begin
            o_dac_data <= '0;
            pause_pend <= 1'b0;
         end else begin
            if (start_ok) begin
               mode_fast  <= i_fast;
               mode_slow0 <= i_slow_0;
               mode_slow1 <= i_slow_1;
               speed      <= speed_in;
               end_addr   <= i_end_addr;
               k          <= '0;
               ended      <= 1'b0;
               pause_pend <= 1'b0;
`ifdef AUD_DSP_REVERSE_EN
               reverse    <= i_reverse;
               ptr        <= i_reverse ? i_end_addr : '0;
`else
               ptr        <= '0;
`endif
            end
            if (go_fetch) begin
               o_sram_rd   <= 1'b1;
               o_sram_addr <= ptr;
               step        <= '0;
            end
            if (state == S_FETCH) begin
               step <= step + 2'd1;
               if (i_pause) pause_pend <= 1'b1;
               // Second read of the interpolation pair, skipped past the data end
               if (mode_slow1 && (step == 2'd0)) begin
                  o_sram_rd   <= b_ok;
                  o_sram_addr <= b_addr;
                  b_pending   <= b_ok;
               end
               if (step == 2'd1) samp_a <= i_sram_data;
               if (fetch_done) begin
                  pause_pend  <= 1'b0;
                  o_dac_valid <= 1'b1;
                  o_dac_data  <= mode_slow1 ? samp_a : i_sram_data;
                  if (mode_slow1) samp_b <= b_pending ? i_sram_data : samp_a;
               end
            end
            if (held_out) begin
               o_dac_valid <= 1'b1;
               o_dac_data  <= mode_slow1 ? interp : samp_a;
            end
            // Phase advance after every emitted sample; pointer moves on wrap
            if (fetch_done || held_out) begin
               if (last_phase) begin
                  k <= '0;
                  if (past_end) ended <= 1'b1;
                  else          ptr   <= ptr_nxt;
               end else begin
                  k <= k + SPD_W'(1);
               end
            end
            if (state == S_DONE) begin
               o_finished <= 1'b1;
               o_dac_data <= '0;
            end
         end
      end
   end

   // Mode flag kept for completeness of the latched configuration
   logic unused_mode;
   assign unused_mode = mode_slow0;

endmodule
`default_nettype wire

// File: tb/tb_aud_dsp_v2.sv
`default_nettype none
// ============================================================================
// Module   : tb_aud_dsp_v2
// Purpose  : Self-checking bench for aud_dsp_v2: directed playback cases,
//            pause/stop/reset handling and randomized playback compared
//            against a sample-sequence reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_aud_dsp_v2;
   localparam int LR_CYC = 32;

   logic        clk = 1'b0;
   logic        lr  = 1'b0;
   logic        rst, start, pause, stop, fast, slow0, slow1, reverse;
   logic [3:0]  speed;
   logic [19:0] end_addr;
   logic        sram_rd;
   logic [19:0] sram_addr;
   logic [15:0] sram_q = '0;
   logic [15:0] dac_data;
   logic        dac_valid, busy, finished;

   logic [15:0] mem [64];
   logic [15:0] got[$];
   logic [15:0] exp_q[$];
   logic [15:0] dac_at_fin;
   int          fin_cnt;
   int          compared = 0;
   int          mismatched = 0;
   bit          timed_out;

   aud_dsp_v2 dut (
      .i_clk(clk), .i_rst(rst), .i_daclrck(lr), .i_start(start), .i_pause(pause),
      .i_stop(stop), .i_speed(speed), .i_fast(fast), .i_slow_0(slow0), .i_slow_1(slow1),
      .i_reverse(reverse), .i_end_addr(end_addr), .o_sram_rd(sram_rd),
      .o_sram_addr(sram_addr), .i_sram_data(sram_q), .o_dac_data(dac_data),
      .o_dac_valid(dac_valid), .o_busy(busy), .o_finished(finished)
   );

   always #5 clk = ~clk;
   always #(LR_CYC * 5) lr = ~lr;

   // SRAM responder: data one cycle after the read strobe
   always @(posedge clk) if (sram_rd) sram_q <= mem[sram_addr[5:0]];

   // Output monitor
   always @(negedge clk) begin
      if (dac_valid) got.push_back(dac_data);
      if (finished) begin
         fin_cnt++;
         dac_at_fin = dac_data;
      end
   end

   // Expected output sequence derived from the playback rules
   task automatic build_model(input int mode, input int spd, input int endp, input bit rev);
      int n, p, dir, a, b, q;
      exp_q.delete();
      n   = (spd == 0) ? 1 : ((spd > 8) ? 8 : spd);
      dir = rev ? -1 : 1;
      p   = rev ? endp : 0;
      while (p >= 0 && p <= endp) begin
         a = int'($signed(mem[p]));
         if (mode == 0) begin
            exp_q.push_back(16'(a));
            p += dir * n;
         end else begin
            b = (p + dir >= 0 && p + dir <= endp) ? int'($signed(mem[p + dir])) : a;
            for (int kk = 0; kk < n; kk++) begin
               q = (mode == 2) ? a + ((b - a) * kk) / n : a;
               exp_q.push_back(16'(q));
            end
            p += dir;
         end
      end
   endtask

   task automatic start_play(input int mode, input int spd, input int endp, input bit rev);
      @(negedge clk);
      got.delete();
      fin_cnt  = 0;
      fast     = (mode == 0);
      slow0    = (mode == 1);
      slow1    = (mode == 2);
      speed    = 4'(spd);
      end_addr = 20'(endp);
      reverse  = rev;
      start    = 1'b1;
      @(negedge clk);
      start    = 1'b0;
      // Configuration changes during playback must have no effect
      speed    = 4'($urandom_range(0, 15));
      end_addr = 20'($urandom_range(0, 40));
      reverse  = ~rev;
      {fast, slow0, slow1} = 3'($urandom_range(0, 7));
   endtask

   task automatic wait_fin(input int budget);
      int cyc = 0;
      while (fin_cnt == 0 && cyc < budget) begin
         @(negedge clk);
         cyc++;
      end
      timed_out = (fin_cnt == 0);
      @(negedge clk);
   endtask

   task automatic wait_outputs(input int cnt);
      int cyc = 0;
      while (got.size() < cnt && cyc < (cnt + 2) * LR_CYC) begin
         @(negedge clk);
         cyc++;
      end
   endtask

   task automatic test_reset();
      compared++;
      if ({sram_rd, sram_addr, dac_data, dac_valid, busy, finished} !== '0) begin
         mismatched++;
         $display("FAIL reset_outputs: got rd=%0b addr=%0h dac=%0h v=%0b busy=%0b fin=%0b, want all 0",
                  sram_rd, sram_addr, dac_data, dac_valid, busy, finished);
      end
   endtask

   task automatic test_fast();
      int e[$] = '{0, 200, 400, 600, 800};
      for (int i = 0; i < 64; i++) mem[i] = 16'(i * 100);
      start_play(0, 2, 9, 1'b0);
      wait_fin(10 * LR_CYC);
      compared++;
      if (timed_out || got.size() != e.size()) begin
         mismatched++;
         $display("FAIL fast_count: got %0d outputs, want %0d (timeout=%0b)", got.size(), e.size(), timed_out);
      end
      for (int i = 0; i < got.size() && i < e.size(); i++) begin
         compared++;
         if (got[i] !== 16'(e[i])) begin
            mismatched++;
            $display("FAIL fast_sample[%0d]: got %0d want %0d", i, $signed(got[i]), e[i]);
         end
      end
      compared++;
      if (fin_cnt != 1 || dac_at_fin !== 16'd0 || busy !== 1'b0) begin
         mismatched++;
         $display("FAIL fast_end: fin=%0d dac=%0h busy=%0b, want 1/0/0", fin_cnt, dac_at_fin, busy);
      end
   endtask

   task automatic test_slow_hold();
      int e[$] = '{5, 5, 5, -7, -7, -7};
      mem[0] = 16'd5;
      mem[1] = 16'hFFF9;
      start_play(1, 3, 1, 1'b0);
      wait_fin(10 * LR_CYC);
      compared++;
      if (timed_out || got.size() != e.size() || fin_cnt != 1) begin
         mismatched++;
         $display("FAIL hold_count: got %0d outputs fin=%0d, want %0d fin=1", got.size(), fin_cnt, e.size());
      end
      for (int i = 0; i < got.size() && i < e.size(); i++) begin
         compared++;
         if (got[i] !== 16'(e[i])) begin
            mismatched++;
            $display("FAIL hold_sample[%0d]: got %0d want %0d", i, $signed(got[i]), e[i]);
         end
      end
   endtask

   task automatic test_slow_interp();
      int e[$] = '{100, 50, 0, -50, -100, -100, -100, -100};
      mem[0] = 16'd100;
      mem[1] = 16'hFF9C;
      start_play(2, 4, 1, 1'b0);
      wait_fin(12 * LR_CYC);
      compared++;
      if (timed_out || got.size() != e.size() || fin_cnt != 1) begin
         mismatched++;
         $display("FAIL interp_count: got %0d outputs fin=%0d, want %0d fin=1", got.size(), fin_cnt, e.size());
      end
      for (int i = 0; i < got.size() && i < e.size(); i++) begin
         compared++;
         if (got[i] !== 16'(e[i])) begin
            mismatched++;
            $display("FAIL interp_sample[%0d]: got %0d want %0d", i, $signed(got[i]), e[i]);
         end
      end
   endtask

   task automatic test_pause();
      int held;
      for (int i = 0; i < 64; i++) mem[i] = 16'(i * 100);
      start_play(0, 1, 7, 1'b0);
      wait_outputs(2);
      pause = 1'b1;
      @(negedge clk);
      pause = 1'b0;
      held = got.size();
      repeat (5 * LR_CYC) @(negedge clk);
      compared++;
      if (held != 2 || got.size() != held || busy !== 1'b1) begin
         mismatched++;
         $display("FAIL pause_hold: outputs %0d->%0d busy=%0b, want 2->2 busy=1", held, got.size(), busy);
      end
      pause = 1'b1;
      @(negedge clk);
      pause = 1'b0;
      wait_fin(12 * LR_CYC);
      compared++;
      if (timed_out || got.size() != 8) begin
         mismatched++;
         $display("FAIL pause_count: got %0d outputs, want 8", got.size());
      end
      for (int i = 0; i < got.size() && i < 8; i++) begin
         compared++;
         if (got[i] !== 16'(i * 100)) begin
            mismatched++;
            $display("FAIL pause_sample[%0d]: got %0d want %0d", i, $signed(got[i]), i * 100);
         end
      end
   endtask

   task automatic test_stop_pause();
      int n_out;
      for (int i = 0; i < 64; i++) mem[i] = 16'($urandom_range(1, 1000));
      start_play(1, 2, 5, 1'b0);
      wait_outputs(3);
      stop  = 1'b1;
      pause = 1'b1;
      @(negedge clk);
      stop  = 1'b0;
      pause = 1'b0;
      compared++;
      if (busy !== 1'b0 || dac_data !== 16'd0) begin
         mismatched++;
         $display("FAIL stop_idle: busy=%0b dac=%0h, want 0/0", busy, dac_data);
      end
      n_out = got.size();
      repeat (3 * LR_CYC) @(negedge clk);
      compared++;
      if (fin_cnt != 0 || got.size() != n_out || busy !== 1'b0) begin
         mismatched++;
         $display("FAIL stop_quiet: fin=%0d outputs %0d->%0d busy=%0b, want 0 and unchanged",
                  fin_cnt, n_out, got.size(), busy);
      end
   endtask

   task automatic test_reset_mid();
      start_play(0, 1, 20, 1'b0);
      wait_outputs(2);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      compared++;
      if (busy !== 1'b0 || dac_data !== 16'd0 || dac_valid !== 1'b0 || sram_rd !== 1'b0) begin
         mismatched++;
         $display("FAIL reset_mid: busy=%0b dac=%0h v=%0b rd=%0b, want all 0", busy, dac_data, dac_valid, sram_rd);
      end
   endtask

   task automatic test_invalid_mode();
      @(negedge clk);
      fast  = 1'b1;
      slow0 = 1'b0;
      slow1 = 1'b1;
      speed = 4'd1;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(negedge clk);
      compared++;
      if (busy !== 1'b0) begin
         mismatched++;
         $display("FAIL invalid_mode: busy=%0b, want 0", busy);
      end
   endtask

   task automatic test_random();
      int mode, spd, endp;
      bit rev;
      for (int t = 0; t < 6; t++) begin
         for (int i = 0; i < 64; i++) mem[i] = 16'($urandom);
         mode = $urandom_range(0, 2);
         spd  = (t == 0) ? 0 : ((t == 1) ? 15 : $urandom_range(1, 8));
         endp = (mode == 0) ? $urandom_range(0, 20) : $urandom_range(0, 5);
`ifdef AUD_DSP_REVERSE_EN
         rev  = 1'($urandom_range(0, 1));
`else
         rev  = 1'b0;
`endif
         build_model(mode, spd, endp, rev);
         start_play(mode, spd, endp, rev);
         wait_fin((exp_q.size() + 4) * LR_CYC);
         compared++;
         if (timed_out || got.size() != exp_q.size() || fin_cnt != 1) begin
            mismatched++;
            $display("FAIL rand%0d_count: got %0d outputs fin=%0d, want %0d fin=1 (mode=%0d N=%0d end=%0d)",
                     t, got.size(), fin_cnt, exp_q.size(), mode, spd, endp);
         end
         for (int i = 0; i < got.size() && i < exp_q.size(); i++) begin
            compared++;
            if (got[i] !== exp_q[i]) begin
               mismatched++;
               $display("FAIL rand%0d_sample[%0d]: got %0d want %0d", t, i, $signed(got[i]), $signed(exp_q[i]));
            end
         end
      end
   endtask

`ifdef AUD_DSP_REVERSE_EN
   task automatic test_reverse();
      int e[$] = '{3, 2, 1, 0};
      for (int i = 0; i < 64; i++) mem[i] = 16'(i);
      start_play(0, 1, 3, 1'b1);
      wait_fin(8 * LR_CYC);
      compared++;
      if (timed_out || got.size() != e.size() || fin_cnt != 1) begin
         mismatched++;
         $display("FAIL reverse_count: got %0d outputs fin=%0d, want 4 fin=1", got.size(), fin_cnt);
      end
      for (int i = 0; i < got.size() && i < e.size(); i++) begin
         compared++;
         if (got[i] !== 16'(e[i])) begin
            mismatched++;
            $display("FAIL reverse_sample[%0d]: got %0d want %0d", i, got[i], e[i]);
         end
      end
   endtask
`endif

   initial begin
      rst = 1'b1; start = 1'b0; pause = 1'b0; stop = 1'b0;
      fast = 1'b0; slow0 = 1'b0; slow1 = 1'b0; reverse = 1'b0;
      speed = '0; end_addr = '0;
      fin_cnt = 0;
      for (int i = 0; i < 64; i++) mem[i] = '0;
      repeat (4) @(negedge clk);
      rst = 1'b0;
      test_reset();
      test_fast();
      test_slow_hold();
      test_slow_interp();
      test_pause();
      test_stop_pause();
      test_reset_mid();
      test_invalid_mode();
      test_random();
`ifdef AUD_DSP_REVERSE_EN
      test_reverse();
`endif
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end
endmodule
`default_nettype wire

// File: doc/aud_dsp_v2.md
# aud_dsp_v2

Parametrised playback DSP between the SRAM controller and the audio DAC player. Once per DAC sample period it fetches recorded samples and produces one output sample, supporting fast play (skip), slow play with sample-hold or linear interpolation, pause/resume, stop and bounded playback length. All logic runs on the system clock; the DAC LR clock is sampled as data.

## Interface
- DATA_W, 16: sample width, signed two's complement
- ADDR_W, 20: SRAM word-address width
- SPD_W, 4: speed field width
- MAX_SPEED, 8: largest legal speed; larger values clamp to MAX_SPEED

- i_clk  in  1  system clock, all flops rising edge
- i_rst  in  1  reset, synchronous, active-high
- i_daclrck  in  1  DAC LR clock, asynchronous to i_clk
- i_start  in  1  one-cycle start pulse
- i_pause  in  1  one-cycle pause/resume toggle pulse
- i_stop  in  1  one-cycle stop pulse
- i_speed  in  SPD_W  speed factor N; 0 treated as 1
- i_fast  in  1  mode select: fast
- i_slow_0  in  1  mode select: slow, sample-hold
- i_slow_1  in  1  mode select: slow, linear interpolation
- i_reverse  in  1  play from i_end_addr toward 0 (see Configuration)
- i_end_addr  in  ADDR_W  last valid recorded address
- o_sram_rd  out  1  read strobe, one cycle per word
- o_sram_addr  out  ADDR_W  read address, valid while o_sram_rd=1
- i_sram_data  in  DATA_W  read data, valid exactly 1 cycle after o_sram_rd
- o_dac_data  out  DATA_W  current output sample, held between updates
- o_dac_valid  out  1  one-cycle pulse when o_dac_data updates
- o_busy  out  1  high in any state except IDLE
- o_finished  out  1  one-cycle pulse on natural end of playback

## Operation
- Reset values: all outputs 0; state IDLE; pointer P=0; phase k=0; held samples A=B=0.
- i_daclrck passes a 2-flop synchroniser; tick = rising edge of synchronised signal (1 i_clk pulse).
- Mode, N, direction, end address latched on accepted start; changes during playback ignored. Mode invalid unless exactly one of i_fast/i_slow_0/i_slow_1 set; start with invalid mode ignored.
- States: IDLE, WAIT (await tick), FETCH (issue reads, capture data), PAUSE, DONE.
- IDLE: start -> WAIT, P=0 (forward) or i_end_addr (reverse), k=0.
- WAIT + tick: fast or k=0 -> FETCH; else compute output from held A,B, k advances, stay WAIT.
- FETCH fast: read mem[P] -> A; output A; P += N (reverse: P -= N).
- FETCH slow_0 (k=0): read mem[P] -> A; output A for N ticks; at k=N-1 wraps to 0 and P steps by 1.
- FETCH slow_1 (k=0): two back-to-back reads mem[P] -> A, mem[P±1] -> B; if P±1 outside [0,i_end_addr], B=A. Output at phase k: A + trunc0((B−A)·k/N), difference computed in DATA_W+1 bits, product in DATA_W+SPD_W+1 bits, truncation toward zero, result fits DATA_W.
- End: when next P would exceed i_end_addr (forward) or go below 0 (reverse), after last sample's phases complete -> DONE: o_finished=1 one cycle, o_dac_data=0, -> IDLE.
- PAUSE: entered from WAIT/FETCH on i_pause after any in-flight FETCH completes; ticks ignored; o_dac_data holds; i_pause -> WAIT with P, k, A, B preserved.
- Stop: from any non-IDLE state -> IDLE next cycle, o_dac_data=0, no o_finished, in-flight read discarded.
- Priority on same cycle: stop > pause > start. Start while busy ignored. Tick arriving in FETCH is dropped (i_clk ≥ 8× tick rate required).
- Reset mid-playback: returns all state to reset values next edge.

## Timing
- Tick detect: 2–3 i_clk after i_daclrck rise.
- Fast / slow_0 k=0: o_sram_rd cycle after tick; o_dac_valid 2 cycles after tick.
- slow_1 k=0: reads in cycles t+1, t+2; o_dac_valid at t+3.
- Held-phase outputs (k>0): o_dac_valid 1 cycle after tick.
- Exactly one o_dac_valid per tick while playing.

## Configuration
- AUD_DSP_REVERSE_EN defined: i_reverse honoured as above.
- Undefined: i_reverse ignored, playback forward only, reverse pointer logic not synthesised.

## Test plan
- Fast N=2, end=9, mem[i]=i·100: outputs 0,200,400,600,800 on successive ticks, then o_finished pulse, o_dac_data=0.
- slow_0 N=3, mem[0..1]=5,−7, end=1: outputs 5,5,5,−7,−7,−7, then finished.
- slow_1 N=4, mem[0]=100, mem[1]=−100, end=1: outputs 100,50,0,−50, then −100×4 (B=A at end).
- Pause after 2nd output, 5 ticks, resume: no o_dac_valid during pause; 3rd output = next expected value.
- Stop and pause same cycle mid-play: IDLE next cycle, o_dac_data=0, o_finished stays 0.
- With AUD_DSP_REVERSE_EN, fast N=1, reverse, end=3, mem[i]=i: outputs 3,2,1,0, then finished.
